gpib_source_hs: RTL and testbench
=================================

Name: gpib_source_hs

Overview:
- Parametrised GPIB talker-side source handshake engine; successor to the single-shot IDLE/ACTIVE/WAIT talker FSM.
- Buffers outgoing bytes in a FIFO and runs the full three-wire handshake (DAV out; NRFD/NDAC in) per byte.
- Adds synchronised bus inputs, settle delay, per-byte ATN tagging, timeout and no-listener detection.
- Sits between the host-side byte producer and the bus driver/transceiver model.

Parameters:
DATA_W, 8, width of data byte on DIO
DEPTH, 8, FIFO depth in entries; power of two, >= 2
SYNC_STAGES, 2, flops on each of nrfd_in and ndac_in; >= 2
SETTLE_CYC, 4, clocks data is held on DIO before DAV asserts; >= 1
TIMEOUT_CYC, 1024, max clocks waiting for NRFD release or NDAC release; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
wr_data  in  DATA_W  byte to transmit
wr_atn  in  1  byte is a command (ATN asserted while it is on the bus)
wr_valid  in  1  write request
wr_ready  out  1  FIFO can accept; write occurs when wr_valid && wr_ready
nrfd_in  in  1  bus NRFD, 1 = asserted (not ready), asynchronous
ndac_in  in  1  bus NDAC, 1 = asserted (not accepted), asynchronous
dio_out  out  DATA_W  byte driven on DIO
dav  out  1  data valid, 1 = asserted
atn  out  1  attention, follows tag of byte in flight
busy  out  1  FSM not in IDLE or FIFO non-empty
level  out  $clog2(DEPTH)+1  FIFO occupancy
err_timeout  out  1  sticky; handshake timed out
err_nolistener  out  1  sticky; NRFD and NDAC both released at LOAD
err_clr  in  1  clears both sticky errors (single-cycle pulse)

Behaviour:
- Reset (async): FIFO empty, level=0, wr_ready=1, dio_out=0, dav=0, atn=0, busy=0, both errors=0, FSM=IDLE, sync flops=1 (asserted). Reset mid-handshake drops DAV immediately and discards all buffered bytes.
- Synchroniser: nrfd_s/ndac_s are nrfd_in/ndac_in delayed SYNC_STAGES clocks; FSM uses only synchronised values.
- FIFO: wr_ready = (level != DEPTH). Write and pop in the same cycle leave level unchanged. Write while full is ignored. Pointers wrap modulo DEPTH.
- IDLE: dav=0, atn=0. If level != 0, go to LOAD.
- LOAD (1 clk): latch head into dio_out/atn (no pop yet).
  - If nrfd_s==0 && ndac_s==0: set err_nolistener, pop/discard byte, go to IDLE.
  - Otherwise go to WAIT_RFD.
- WAIT_RFD: hold DIO/ATN; wait for nrfd_s==0, then go to SETTLE. Timeout counter runs.
- SETTLE: count SETTLE_CYC clocks, then go to WAIT_DAC with dav=1 from the first WAIT_DAC cycle.
- WAIT_DAC: dav=1; wait for ndac_s==0 (byte accepted), then pop FIFO, dav=0 next clock, go to IDLE. Timeout counter runs.
- Timeout: counter clears on entry to WAIT_RFD/WAIT_DAC. Reaching TIMEOUT_CYC sets err_timeout, forces dav=0, pops/discards the byte, goes to IDLE. TIMEOUT_CYC=0 waits forever.
- dio_out keeps its last value in IDLE; atn returns to 0 in IDLE.
- Errors: err_clr clears both; a set event in the same cycle wins over clear. Errors do not block further transfers.
- Minimum per-byte time: 1 (IDLE) + 1 (LOAD) + 1 + SETTLE_CYC + 1, plus SYNC_STAGES latency on each bus response.

Decomposition:
- gpib_pkg holds the state_t enum {IDLE, LOAD, WAIT_RFD, SETTLE, WAIT_DAC} and a fifo entry struct {atn, data}.
- One sub-module: gpib_sync_fifo (parametrised DATA_W+1 wide, DEPTH deep, level output).
- Synchronisers are inline.

Test Plan:
- Single byte: write 0xA5 atn=0; listener model holds NRFD=1 for 10 clk then releases, asserts NRFD, releases NDAC when DAV seen -> dio_out=0xA5, DAV rises exactly SETTLE_CYC+1 clk after nrfd_s falls, DAV falls 1 clk after ndac_s falls, level 1->0.
- Burst/full: write 9 bytes 0x00..0x08 with DEPTH=8 and listener stalled -> wr_ready=0 after 8th accepted, 9th ignored; releasing listener yields exactly 0x00..0x07 in order with correct atn tags.
- ATN command: write 0x3F atn=1 then 0x41 atn=0 -> atn=1 during first handshake, 0 in IDLE gap and during second.
- Timeout: TIMEOUT_CYC=16, NDAC never releases -> DAV held 16 clk then drops, err_timeout=1, level decremented, next byte proceeds; err_clr pulse -> err_timeout=0.
- No listener: nrfd_in=ndac_in=0 before write -> err_nolistener=1 after LOAD, DAV never asserts, byte discarded.
- Reset mid-transfer: assert rst_n low while dav=1 with 3 bytes queued -> dav=0, level=0, wr_ready=1 immediately (asynchronously).

Source files
------------

// File: rtl/gpib_pkg.sv
// Shared types and helpers for the GPIB talker-side source handshake engine.
// The FIFO entry layout depends on DATA_W, so the top declares it locally.
package gpib_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_RFD,
      SETTLE,
      WAIT_DAC
   } state_t;

   // Width of the shared settle/timeout counter. It must hold values up to max(a, b) - 1.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/gpib_sync_fifo.sv
// Single-clock FIFO with an occupancy count. Writes are dropped while the FIFO is full,
// and pops are ignored while it is empty. The head entry is presented combinationally.
module gpib_sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   output logic [WIDTH-1:0]       rd_data,
   input  logic                   rd_pop,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   always_comb begin
      wr_ready = (level_q != LW'(DEPTH));
      do_wr    = wr_valid && wr_ready;
      do_rd    = rd_pop && (level_q != '0);
      // Power-of-two depth lets the pointers wrap naturally.
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      level_d  = level_q + LW'(do_wr) - LW'(do_rd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

endmodule

// File: rtl/gpib_source_hs.sv
// GPIB talker source handshake engine. It queues bytes with per-byte ATN tags and drives
// DIO/DAV/ATN through the full NRFD/NDAC handshake, with timeout and no-listener detection.
module gpib_source_hs
   import gpib_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   wr_atn,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic                   nrfd_in,
   input  logic                   ndac_in,
   output logic [DATA_W-1:0]      dio_out,
   output logic                   dav,
   output logic                   atn,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   err_timeout,
   output logic                   err_nolistener,
   input  logic                   err_clr
);

   localparam int unsigned CntW = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
   localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   typedef struct packed {
      logic              atn;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            wr_entry, head;
   logic [DATA_W:0]   head_raw;
   logic              pop;

   logic [SYNC_STAGES-1:0] nrfd_sync_q, nrfd_sync_d;
   logic [SYNC_STAGES-1:0] ndac_sync_q, ndac_sync_d;
   logic                   nrfd_s, ndac_s;

   state_t            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] dio_q, dio_d;
   logic              atn_q, atn_d;
   logic              dav_q, dav_d;
   logic              err_to_q, err_to_d;
   logic              err_nl_q, err_nl_d;
   logic              set_to, set_nl, timeout_hit;

   always_comb begin
      wr_entry.atn  = wr_atn;
      wr_entry.data = wr_data;
      head          = entry_t'(head_raw);
   end

   gpib_sync_fifo #(
      .WIDTH(DATA_W + 1),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_data (wr_entry),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .rd_data (head_raw),
      .rd_pop  (pop),
      .level   (level)
   );

   // Bus lines reset to "asserted" so a stale release is never seen straight out of reset.
   always_comb begin
      nrfd_sync_d = {nrfd_sync_q[SYNC_STAGES-2:0], nrfd_in};
      ndac_sync_d = {ndac_sync_q[SYNC_STAGES-2:0], ndac_in};
      nrfd_s      = nrfd_sync_q[SYNC_STAGES-1];
      ndac_s      = ndac_sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nrfd_sync_q <= '1;
         ndac_sync_q <= '1;
      end else begin
         nrfd_sync_q <= nrfd_sync_d;
         ndac_sync_q <= ndac_sync_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dio_d       = dio_q;
      atn_d       = atn_q;
      pop         = 1'b0;
      set_to      = 1'b0;
      set_nl      = 1'b0;
      timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TimeoutLast);

      unique case (state_q)
         IDLE: begin
            if (level != '0) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            dio_d = head.data;
            if (!nrfd_s && !ndac_s) begin
               set_nl  = 1'b1;
               pop     = 1'b1;
               state_d = IDLE;
            end else begin
               atn_d   = head.atn;
               cnt_d   = '0;
               state_d = WAIT_RFD;
            end
         end
         WAIT_RFD: begin
            if (!nrfd_s) begin
               cnt_d   = '0;
               state_d = SETTLE;
            end else if (timeout_hit) begin
               set_to  = 1'b1;
               pop     = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q == SettleLast) begin
               cnt_d   = '0;
               state_d = WAIT_DAC;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DAC: begin
            if (!ndac_s) begin
               pop     = 1'b1;
               state_d = IDLE;
            end else if (timeout_hit) begin
               set_to  = 1'b1;
               pop     = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // DAV and ATN are registered from the next state, so they change on the state edge.
      if (state_d == IDLE) begin
         atn_d = 1'b0;
      end
      dav_d = (state_d == WAIT_DAC);

      err_to_d = err_clr ? 1'b0 : err_to_q;
      err_nl_d = err_clr ? 1'b0 : err_nl_q;
      if (set_to) begin
         err_to_d = 1'b1;
      end
      if (set_nl) begin
         err_nl_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dio_q    <= '0;
         atn_q    <= 1'b0;
         dav_q    <= 1'b0;
         err_to_q <= 1'b0;
         err_nl_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dio_q    <= dio_d;
         atn_q    <= atn_d;
         dav_q    <= dav_d;
         err_to_q <= err_to_d;
         err_nl_q <= err_nl_d;
      end
   end

   assign dio_out        = dio_q;
   assign dav            = dav_q;
   assign atn            = atn_q;
   assign busy           = (state_q != IDLE) || (level != '0);
   assign err_timeout    = err_to_q;
   assign err_nolistener = err_nl_q;

endmodule

// File: tb/tb_gpib_source_hs.sv
// Directed bench for gpib_source_hs: a table of single-byte transfers, plus hand-written
// sequences for timing, FIFO full, ATN tagging, timeout, no-listener and async reset.
module tb_gpib_source_hs;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned DEPTH       = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned SETTLE_CYC  = 4;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] wr_data;
   logic              wr_atn;
   logic              wr_valid;
   logic              wr_ready;
   logic              nrfd_in;
   logic              ndac_in;
   logic [DATA_W-1:0] dio_out;
   logic              dav;
   logic              atn;
   logic              busy;
   logic [3:0]        level;
   logic              err_timeout;
   logic              err_nolistener;
   logic              err_clr;

   gpib_source_hs #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SYNC_STAGES),
      .SETTLE_CYC (SETTLE_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_data       (wr_data),
      .wr_atn        (wr_atn),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .nrfd_in       (nrfd_in),
      .ndac_in       (ndac_in),
      .dio_out       (dio_out),
      .dav           (dav),
      .atn           (atn),
      .busy          (busy),
      .level         (level),
      .err_timeout   (err_timeout),
      .err_nolistener(err_nolistener),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       atn_tag;
      logic [7:0] exp_dio;
      logic       exp_atn;
   } vec_t;

   vec_t vecs[5];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d, input logic a);
      wr_data  = d;
      wr_atn   = a;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   // Listener model: release NRFD, on DAV assert NRFD and release NDAC, re-assert NDAC after DAV drops.
   task automatic handshake(output logic [7:0] d, output logic a, output int rise, output int fall);
      tick();
      nrfd_in = 1'b0;
      rise    = 0;
      while (dav !== 1'b1 && rise < 200) begin
         tick();
         rise++;
      end
      if (dav !== 1'b1) check("hs_dav_rise_bound", {31'd0, dav}, 32'd1);
      d       = dio_out;
      a       = atn;
      nrfd_in = 1'b1;
      ndac_in = 1'b0;
      fall    = 0;
      while (dav !== 1'b0 && fall < 200) begin
         tick();
         fall++;
      end
      if (dav !== 1'b0) check("hs_dav_fall_bound", {31'd0, dav}, 32'd0);
      ndac_in = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       a;
      int         rise, fall, n;
      logic       seen_dav;

      vecs[0] = '{data: 8'h00, atn_tag: 1'b0, exp_dio: 8'h00, exp_atn: 1'b0};
      vecs[1] = '{data: 8'hFF, atn_tag: 1'b1, exp_dio: 8'hFF, exp_atn: 1'b1};
      vecs[2] = '{data: 8'h5A, atn_tag: 1'b0, exp_dio: 8'h5A, exp_atn: 1'b0};
      vecs[3] = '{data: 8'h3C, atn_tag: 1'b1, exp_dio: 8'h3C, exp_atn: 1'b1};
      vecs[4] = '{data: 8'h81, atn_tag: 1'b0, exp_dio: 8'h81, exp_atn: 1'b0};

      rst_n    = 1'b1;
      nrfd_in  = 1'b1;
      ndac_in  = 1'b1;
      wr_valid = 1'b0;
      wr_data  = '0;
      wr_atn   = 1'b0;
      err_clr  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_dav", {31'd0, dav}, 32'd0);
      check("rst_level", {28'd0, level}, 32'd0);
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("rst_dio", {24'd0, dio_out}, 32'd0);
      check("rst_atn", {31'd0, atn}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err_to", {31'd0, err_timeout}, 32'd0);
      check("rst_err_nl", {31'd0, err_nolistener}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single byte with exact DAV timing: rise = SYNC_STAGES + SETTLE_CYC + 1, fall = SYNC_STAGES + 1.
      write_byte(8'hA5, 1'b0);
      check("sb_level_1", {28'd0, level}, 32'd1);
      check("sb_busy", {31'd0, busy}, 32'd1);
      repeat (9) tick();
      check("sb_dio_held", {24'd0, dio_out}, 32'hA5);
      check("sb_dav_low_wait", {31'd0, dav}, 32'd0);
      handshake(d, a, rise, fall);
      check("sb_dio", {24'd0, d}, 32'hA5);
      check("sb_atn", {31'd0, a}, 32'd0);
      check("sb_rise_cycles", rise, 32'd7);
      check("sb_fall_cycles", fall, 32'd3);
      check("sb_level_0", {28'd0, level}, 32'd0);
      check("sb_no_timeout", {31'd0, err_timeout}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         write_byte(vecs[i].data, vecs[i].atn_tag);
         handshake(d, a, rise, fall);
         check($sformatf("vec%0d_dio", i), {24'd0, d}, {24'd0, vecs[i].exp_dio});
         check($sformatf("vec%0d_atn", i), {31'd0, a}, {31'd0, vecs[i].exp_atn});
         check($sformatf("vec%0d_atn_idle", i), {31'd0, atn}, 32'd0);
         check($sformatf("vec%0d_level", i), {28'd0, level}, 32'd0);
         check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
      end

      // ATN command followed by a data byte.
      write_byte(8'h3F, 1'b1);
      write_byte(8'h41, 1'b0);
      handshake(d, a, rise, fall);
      check("atn_cmd_dio", {24'd0, d}, 32'h3F);
      check("atn_cmd_atn", {31'd0, a}, 32'd1);
      check("atn_gap", {31'd0, atn}, 32'd0);
      handshake(d, a, rise, fall);
      check("atn_data_dio", {24'd0, d}, 32'h41);
      check("atn_data_atn", {31'd0, a}, 32'd0);

      // Burst into a stalled listener: the ninth write must be dropped.
      for (int i = 0; i < 9; i++) begin
         write_byte(8'(i), 1'(i % 2));
         if (i == 7) begin
            check("full_level", {28'd0, level}, 32'd8);
            check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
         end
      end
      check("full_level_after_9th", {28'd0, level}, 32'd8);
      for (int i = 0; i < 8; i++) begin
         handshake(d, a, rise, fall);
         check($sformatf("burst%0d_dio", i), {24'd0, d}, i);
         check($sformatf("burst%0d_atn", i), {31'd0, a}, i % 2);
      end
      check("burst_level_0", {28'd0, level}, 32'd0);
      repeat (10) tick();
      check("burst_idle_busy", {31'd0, busy}, 32'd0);
      check("burst_idle_dav", {31'd0, dav}, 32'd0);

      // Timeout: NDAC never releases.
      write_byte(8'h11, 1'b0);
      write_byte(8'h22, 1'b1);
      tick();
      nrfd_in = 1'b0;
      n = 0;
      while (dav !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("to_dav_rise", {31'd0, dav}, 32'd1);
      nrfd_in = 1'b1;
      n = 0;
      while (dav === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("to_dav_high_cycles", n, TIMEOUT_CYC);
      check("to_err_set", {31'd0, err_timeout}, 32'd1);
      check("to_level", {28'd0, level}, 32'd1);
      handshake(d, a, rise, fall);
      check("to_next_dio", {24'd0, d}, 32'h22);
      check("to_next_atn", {31'd0, a}, 32'd1);
      check("to_err_sticky", {31'd0, err_timeout}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("to_err_cleared", {31'd0, err_timeout}, 32'd0);

      // No listener; err_clr is held over the set edge, where the set must win.
      nrfd_in = 1'b0;
      ndac_in = 1'b0;
      repeat (3) tick();
      write_byte(8'h77, 1'b0);
      seen_dav = dav;
      err_clr  = 1'b1;
      tick();
      seen_dav |= dav;
      tick();
      err_clr = 1'b0;
      check("nl_err_set_wins", {31'd0, err_nolistener}, 32'd1);
      check("nl_level", {28'd0, level}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         seen_dav |= dav;
      end
      check("nl_no_dav", {31'd0, seen_dav}, 32'd0);
      check("nl_busy", {31'd0, busy}, 32'd0);
      nrfd_in = 1'b1;
      ndac_in = 1'b1;
      repeat (3) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("nl_err_cleared", {31'd0, err_nolistener}, 32'd0);

      // Asynchronous reset while DAV is asserted with bytes still queued.
      write_byte(8'hA1, 1'b0);
      write_byte(8'hA2, 1'b0);
      write_byte(8'hA3, 1'b0);
      tick();
      nrfd_in = 1'b0;
      n = 0;
      while (dav !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("rmt_dav_up", {31'd0, dav}, 32'd1);
      check("rmt_level_before", {28'd0, level}, 32'd3);
      rst_n = 1'b0;
      #1;
      check("rmt_dav", {31'd0, dav}, 32'd0);
      check("rmt_level", {28'd0, level}, 32'd0);
      check("rmt_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("rmt_busy", {31'd0, busy}, 32'd0);
      nrfd_in = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      write_byte(8'h5C, 1'b0);
      handshake(d, a, rise, fall);
      check("rmt_post_dio", {24'd0, d}, 32'h5C);
      check("rmt_post_level", {28'd0, level}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
